// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX pipeline register with MEM/WB operand forwarding
// Holds the decoded instruction for EX, picks ALU operands and flags load-use hazards.
module ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_rd_wren,
  input  logic              id_is_load,
  input  logic              id_opa_sel,
  input  logic              id_opb_sel,
  input  logic [3:0]        id_alu_sel,
  input  logic              mem_valid,
  input  logic              mem_rd_wren,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              wb_valid,
  input  logic              wb_rd_wren,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   oprand_a,
  output logic [XLEN-1:0]   oprand_b,
  output logic [3:0]        alu_sel,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_rd_wren,
  output logic              ex_is_load,
  output logic              load_use_hazard
);

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [REG_AW-1:0] r_rs1_addr;
  logic [REG_AW-1:0] r_rs2_addr;
  logic [REG_AW-1:0] r_rd_addr;
  logic              r_rd_wren;
  logic              r_is_load;
  logic              r_opa_sel;
  logic              r_opb_sel;
  logic [3:0]        r_alu_sel;

  logic              w_mem_hit_rs1;
  logic              w_mem_hit_rs2;
  logic              w_wb_hit_rs1;
  logic              w_wb_hit_rs2;
  logic [XLEN-1:0]   w_fwd_rs1;
  logic [XLEN-1:0]   w_fwd_rs2;
  logic              w_rd_live;

  // x0 is hard-wired zero, so a producer targeting it never forwards.
  assign w_mem_hit_rs1 = mem_valid & mem_rd_wren & (mem_rd_addr == r_rs1_addr) & (r_rs1_addr != '0);
  assign w_mem_hit_rs2 = mem_valid & mem_rd_wren & (mem_rd_addr == r_rs2_addr) & (r_rs2_addr != '0);
  assign w_wb_hit_rs1  = wb_valid  & wb_rd_wren  & (wb_rd_addr  == r_rs1_addr) & (r_rs1_addr != '0);
  assign w_wb_hit_rs2  = wb_valid  & wb_rd_wren  & (wb_rd_addr  == r_rs2_addr) & (r_rs2_addr != '0);

  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    if (w_mem_hit_rs1) begin
      w_fwd_rs1 = mem_data;
    end else if (w_wb_hit_rs1) begin
      w_fwd_rs1 = wb_data;
    end
  end

  always_comb begin
    w_fwd_rs2 = r_rs2_data;
    if (w_mem_hit_rs2) begin
      w_fwd_rs2 = mem_data;
    end else if (w_wb_hit_rs2) begin
      w_fwd_rs2 = wb_data;
    end
  end

  // During a stall the operands are re-captured so a producer retiring past WB is kept.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_rd_wren  <= 1'b0;
      r_is_load  <= 1'b0;
      r_opa_sel  <= 1'b0;
      r_opb_sel  <= 1'b0;
      r_alu_sel  <= '0;
    end else if (stall) begin
      r_rs1_data <= w_fwd_rs1;
      r_rs2_data <= w_fwd_rs2;
    end else begin
      r_valid    <= id_valid;
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_rs1_addr <= id_rs1_addr;
      r_rs2_addr <= id_rs2_addr;
      r_rd_addr  <= id_rd_addr;
      r_rd_wren  <= id_rd_wren;
      r_is_load  <= id_is_load;
      r_opa_sel  <= id_opa_sel;
      r_opb_sel  <= id_opb_sel;
      r_alu_sel  <= id_alu_sel;
    end
  end

  assign w_rd_live     = r_valid & r_rd_wren;

  assign ex_valid      = r_valid;
  assign ex_pc         = r_pc;
  assign oprand_a      = r_opa_sel ? r_pc  : w_fwd_rs1;
  assign oprand_b      = r_opb_sel ? r_imm : w_fwd_rs2;
  assign alu_sel       = r_alu_sel;
  assign ex_store_data = w_fwd_rs2;
  assign ex_rd_addr    = r_rd_addr;
  assign ex_rd_wren    = w_rd_live;
  assign ex_is_load    = r_is_load;

  assign load_use_hazard = w_rd_live & r_is_load & (r_rd_addr != '0) & id_valid &
                           ((id_rs1_used & (id_rs1_addr == r_rd_addr)) |
                            (id_rs2_used & (id_rs2_addr == r_rd_addr)));

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - self-checking bench for ex_operand_stage
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_rs1_used, id_rs2_used, id_rd_wren, id_is_load, id_opa_sel, id_opb_sel;
  logic [3:0]  id_alu_sel;
  logic        mem_valid, mem_rd_wren, wb_valid, wb_rd_wren;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic [31:0] mem_data, wb_data;
  logic        ex_valid, ex_rd_wren, ex_is_load, load_use_hazard;
  logic [31:0] ex_pc, oprand_a, oprand_b, ex_store_data;
  logic [3:0]  alu_sel;
  logic [4:0]  ex_rd_addr;

  int n_checks = 0;
  int n_fail   = 0;

  ex_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd_wren(id_rd_wren),
    .id_is_load(id_is_load), .id_opa_sel(id_opa_sel), .id_opb_sel(id_opb_sel), .id_alu_sel(id_alu_sel),
    .mem_valid(mem_valid), .mem_rd_wren(mem_rd_wren), .mem_rd_addr(mem_rd_addr), .mem_data(mem_data),
    .wb_valid(wb_valid), .wb_rd_wren(wb_rd_wren), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .oprand_a(oprand_a), .oprand_b(oprand_b), .alu_sel(alu_sel),
    .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr), .ex_rd_wren(ex_rd_wren),
    .ex_is_load(ex_is_load), .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction EX currently holds, as plain fields.
  logic        m_valid, m_wren, m_load, m_opa, m_opb;
  logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [4:0]  m_rs1a, m_rs2a, m_rd;
  logic [3:0]  m_alu;

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] regd);
    if (a != 0 && mem_valid && mem_rd_wren && mem_rd_addr == a) return mem_data;
    if (a != 0 && wb_valid && wb_rd_wren && wb_rd_addr == a) return wb_data;
    return regd;
  endfunction

  task automatic model_clock;
    logic [31:0] f1, f2;
    f1 = fwd(m_rs1a, m_rs1d);
    f2 = fwd(m_rs2a, m_rs2d);
    if (rst || flush) begin
      {m_valid, m_wren, m_load, m_opa, m_opb} = '0;
      {m_pc, m_rs1d, m_rs2d, m_imm} = '0;
      {m_rs1a, m_rs2a, m_rd} = '0;
      m_alu = '0;
    end else if (stall) begin
      m_rs1d = f1;
      m_rs2d = f2;
    end else begin
      m_valid = id_valid; m_wren = id_rd_wren; m_load = id_is_load;
      m_opa = id_opa_sel; m_opb = id_opb_sel;
      m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm;
      m_rs1a = id_rs1_addr; m_rs2a = id_rs2_addr; m_rd = id_rd_addr; m_alu = id_alu_sel;
    end
  endtask

  task automatic tick;
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic live, haz;
    live = m_valid & m_wren;
    haz = live & m_load & (m_rd != 0) & id_valid &
          ((id_rs1_used & id_rs1_addr == m_rd) | (id_rs2_used & id_rs2_addr == m_rd));
    chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(m_valid));
    chk({tag, ".ex_pc"}, ex_pc, m_pc);
    chk({tag, ".oprand_a"}, oprand_a, m_opa ? m_pc : fwd(m_rs1a, m_rs1d));
    chk({tag, ".oprand_b"}, oprand_b, m_opb ? m_imm : fwd(m_rs2a, m_rs2d));
    chk({tag, ".store"}, ex_store_data, fwd(m_rs2a, m_rs2d));
    chk({tag, ".alu_sel"}, 32'(alu_sel), 32'(m_alu));
    chk({tag, ".rd_addr"}, 32'(ex_rd_addr), 32'(m_rd));
    chk({tag, ".rd_wren"}, 32'(ex_rd_wren), 32'(live));
    chk({tag, ".is_load"}, 32'(ex_is_load), 32'(m_load));
    chk({tag, ".hazard"}, 32'(load_use_hazard), 32'(haz));
  endtask

  task automatic idle;
    rst = 0; stall = 0; flush = 0;
    id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
    id_rs1_used = 0; id_rs2_used = 0; id_rd_wren = 0; id_is_load = 0;
    id_opa_sel = 0; id_opb_sel = 0; id_alu_sel = 0;
    mem_valid = 0; mem_rd_wren = 0; mem_rd_addr = 0; mem_data = 0;
    wb_valid = 0; wb_rd_wren = 0; wb_rd_addr = 0; wb_data = 0;
  endtask

  typedef struct {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a;
    logic        opa, opb;
    logic        mv, mw;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        wv, ww;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] ea, eb, es;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{32'h100, 32'd5, 32'h8, 32'hFFFFFFFC, 5'd1, 5'd2, 1'b0, 1'b1,
                1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 32'd5, 32'hFFFFFFFC, 32'h8};
    vecs[1] = '{32'h104, 32'h99, 32'h8, 32'h0, 5'd3, 5'd2, 1'b0, 1'b0,
                1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 1'b1, 5'd3, 32'h22, 32'h11, 32'h8, 32'h8};
    vecs[2] = '{32'h108, 32'h99, 32'h8, 32'h0, 5'd3, 5'd2, 1'b0, 1'b0,
                1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 1'b1, 5'd3, 32'h22, 32'h22, 32'h8, 32'h8};
    vecs[3] = '{32'h10C, 32'h99, 32'h8, 32'h0, 5'd0, 5'd2, 1'b0, 1'b0,
                1'b1, 1'b1, 5'd0, 32'h11, 1'b1, 1'b1, 5'd0, 32'h22, 32'h99, 32'h8, 32'h8};
    vecs[4] = '{32'h1000, 32'h99, 32'h8, 32'h0, 5'd3, 5'd2, 1'b1, 1'b0,
                1'b1, 1'b1, 5'd3, 32'h11, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1000, 32'h8, 32'h8};
    vecs[5] = '{32'h110, 32'h77, 32'h8, 32'h0, 5'd1, 5'd9, 1'b0, 1'b0,
                1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd9, 32'h55, 32'h77, 32'h55, 32'h55};
    vecs[6] = '{32'h114, 32'h77, 32'h8, 32'h7, 5'd1, 5'd9, 1'b0, 1'b1,
                1'b1, 1'b1, 5'd9, 32'hAA, 1'b1, 1'b1, 5'd9, 32'h55, 32'h77, 32'h7, 32'hAA};
    vecs[7] = '{32'h118, 32'h99, 32'h8, 32'h0, 5'd3, 5'd2, 1'b0, 1'b0,
                1'b1, 1'b0, 5'd3, 32'h11, 1'b0, 1'b0, 5'd0, 32'h0, 32'h99, 32'h8, 32'h8};
    vecs[8] = '{32'h11C, 32'h99, 32'h8, 32'h0, 5'd3, 5'd2, 1'b0, 1'b0,
                1'b1, 1'b1, 5'd4, 32'h11, 1'b1, 1'b0, 5'd3, 32'h22, 32'h99, 32'h8, 32'h8};
  end

  initial begin
    idle();
    {m_valid, m_wren, m_load, m_opa, m_opb} = '0;
    {m_pc, m_rs1d, m_rs2d, m_imm} = '0;
    {m_rs1a, m_rs2a, m_rd} = '0;
    m_alu = '0;
    #1;

    // Reset wins over stall with a live decode slot.
    rst = 1; stall = 1; id_valid = 1; id_pc = 32'h40; id_rs1_data = 32'h3;
    id_opa_sel = 1; id_alu_sel = 4'h5;
    tick(); tick();
    chk("rst.ex_valid", 32'(ex_valid), 0);
    chk("rst.oprand_a", oprand_a, 0);
    chk("rst.oprand_b", oprand_b, 0);
    chk("rst.alu_sel", 32'(alu_sel), 0);
    chk("rst.hazard", 32'(load_use_hazard), 0);
    idle();

    // Table-driven load + forwarding vectors.
    for (int i = 0; i < 9; i++) begin
      idle();
      id_valid = 1; id_pc = vecs[i].pc; id_rs1_data = vecs[i].rs1d; id_rs2_data = vecs[i].rs2d;
      id_imm = vecs[i].imm; id_rs1_addr = vecs[i].rs1a; id_rs2_addr = vecs[i].rs2a;
      id_opa_sel = vecs[i].opa; id_opb_sel = vecs[i].opb; id_alu_sel = 4'(i);
      tick();
      idle();
      mem_valid = vecs[i].mv; mem_rd_wren = vecs[i].mw; mem_rd_addr = vecs[i].ma; mem_data = vecs[i].md;
      wb_valid = vecs[i].wv; wb_rd_wren = vecs[i].ww; wb_rd_addr = vecs[i].wa; wb_data = vecs[i].wd;
      #1;
      chk($sformatf("vec%0d.oprand_a", i), oprand_a, vecs[i].ea);
      chk($sformatf("vec%0d.oprand_b", i), oprand_b, vecs[i].eb);
      chk($sformatf("vec%0d.store", i), ex_store_data, vecs[i].es);
      chk($sformatf("vec%0d.ex_valid", i), 32'(ex_valid), 1);
      chk($sformatf("vec%0d.alu_sel", i), 32'(alu_sel), i);
    end

    // Load-use: lw x7 in EX.
    idle();
    id_valid = 1; id_is_load = 1; id_rd_wren = 1; id_rd_addr = 7;
    tick();
    idle();
    id_valid = 1; id_rs2_used = 1; id_rs2_addr = 7; #1;
    chk("lu.rs2_hit", 32'(load_use_hazard), 1);
    id_rs2_used = 0; #1;
    chk("lu.rs2_unused", 32'(load_use_hazard), 0);
    id_rs1_used = 1; id_rs1_addr = 7; #1;
    chk("lu.rs1_hit", 32'(load_use_hazard), 1);
    id_valid = 0; #1;
    chk("lu.id_invalid", 32'(load_use_hazard), 0);
    idle();
    id_valid = 1; id_is_load = 1; id_rd_wren = 1; id_rd_addr = 0;
    tick();
    idle();
    id_valid = 1; id_rs2_used = 1; id_rs2_addr = 0; #1;
    chk("lu.rd_x0", 32'(load_use_hazard), 0);

    // Stall while a WB producer retires in the first stall cycle only.
    idle();
    id_valid = 1; id_pc = 32'h200; id_rs2_addr = 4; id_rs2_data = 32'h1111;
    id_rd_addr = 5; id_rd_wren = 1; id_alu_sel = 4'h3;
    tick();
    idle();
    id_valid = 1; id_pc = 32'h999; id_rd_addr = 9; id_rs2_data = 32'h2222; id_alu_sel = 4'h7;
    stall = 1; wb_valid = 1; wb_rd_wren = 1; wb_rd_addr = 4; wb_data = 32'hABCD; #1;
    chk("st.c1.oprand_b", oprand_b, 32'hABCD);
    tick();
    wb_valid = 0; wb_data = 0; #1;
    chk("st.c2.oprand_b", oprand_b, 32'hABCD);
    tick();
    chk("st.c3.oprand_b", oprand_b, 32'hABCD);
    chk("st.c3.ex_pc", ex_pc, 32'h200);
    chk("st.c3.rd_addr", 32'(ex_rd_addr), 5);
    chk("st.c3.alu_sel", 32'(alu_sel), 3);
    tick();
    stall = 0; #1;
    chk("st.rel.oprand_b", oprand_b, 32'hABCD);
    chk("st.rel.ex_valid", 32'(ex_valid), 1);
    chk("st.rel.rd_wren", 32'(ex_rd_wren), 1);

    // Flush beats stall.
    idle();
    id_valid = 1; id_rs1_data = 32'h1234; id_rs1_addr = 2; id_rd_addr = 6; id_rd_wren = 1;
    tick();
    idle();
    flush = 1; stall = 1;
    tick();
    flush = 0; stall = 0; #1;
    chk("fl.ex_valid", 32'(ex_valid), 0);
    chk("fl.rd_wren", 32'(ex_rd_wren), 0);
    chk("fl.oprand_a", oprand_a, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 3) == 0);
      id_valid = 1'($urandom); id_pc = $urandom; id_rs1_data = $urandom;
      id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1_addr = 5'($urandom_range(0, 7)); id_rs2_addr = 5'($urandom_range(0, 7));
      id_rd_addr = 5'($urandom_range(0, 7));
      id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom); id_rd_wren = 1'($urandom);
      id_is_load = 1'($urandom); id_opa_sel = 1'($urandom); id_opb_sel = 1'($urandom);
      id_alu_sel = 4'($urandom);
      mem_valid = 1'($urandom); mem_rd_wren = 1'($urandom);
      mem_rd_addr = 5'($urandom_range(0, 7)); mem_data = $urandom;
      wb_valid = 1'($urandom); wb_rd_wren = 1'($urandom);
      wb_rd_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
      #1;
      check_model($sformatf("rnd%0d", c));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand forwarding; sits directly upstream of the ALU.
- Captures decoded fields from decode each cycle, applies MEM/WB forwarding to the rs1/rs2 values, and selects the ALU operands (oprand_a: rs1 or PC; oprand_b: rs2 or immediate) together with alu_sel.
- Raises load-use hazard detection toward the pipeline controller.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  hold stage contents.
- flush  in  1  insert bubble.
- id_valid  in  1  decode slot holds an instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  REG_AW  register indices.
- id_rs1_used, id_rs2_used  in  1  instruction reads rs1 / rs2.
- id_rd_wren  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- id_opa_sel  in  1  0 = rs1, 1 = PC.
- id_opb_sel  in  1  0 = rs2, 1 = imm.
- id_alu_sel  in  4  ALU operation code (cpu_def.vh encoding).
- mem_valid, mem_rd_wren  in  1  MEM-stage producer qualifiers.
- mem_rd_addr  in  REG_AW  MEM-stage destination.
- mem_data  in  XLEN  MEM-stage ALU result.
- wb_valid, wb_rd_wren  in  1  WB-stage producer qualifiers.
- wb_rd_addr  in  REG_AW  WB-stage destination.
- wb_data  in  XLEN  WB-stage write data.
- ex_valid  out  1  EX holds a live instruction.
- ex_pc  out  XLEN  registered PC.
- oprand_a, oprand_b  out  XLEN  ALU operands.
- alu_sel  out  4  registered ALU operation.
- ex_store_data  out  XLEN  forwarded rs2 value (stores/branches).
- ex_rd_addr  out  REG_AW  registered destination.
- ex_rd_wren  out  1  registered write enable, forced 0 when ex_valid = 0.
- ex_is_load  out  1  registered load flag.
- load_use_hazard  out  1  combinational hazard request.

Behaviour:
- Clock and reset: one clock; reset is synchronous, active-high.
- Reset value of every output: all registered fields are 0, so ex_valid, ex_rd_wren, ex_is_load, alu_sel, ex_pc and ex_rd_addr are 0. With all registered fields 0, oprand_a, oprand_b and ex_store_data are 0 and load_use_hazard is 0.
- Update priority per clock edge: rst > flush > stall > load.
  - load: all id_* fields are captured; 1-cycle latency from decode to ALU inputs.
  - flush: bubble. Every registered field is 0, so ex_valid = 0 and ex_rd_wren = 0. Flush wins over a simultaneous stall.
  - stall: all control fields, PC, imm and addresses are held. Registered rs1_data/rs2_data are reloaded with the current forwarded values fwd_rs1/fwd_rs2. This way a producer that retires past WB during the stall is not lost.
- Forwarding (combinational, from registered state):
  - fwd_rs1 = mem_data if mem_valid & mem_rd_wren & mem_rd_addr == rs1_addr & rs1_addr != 0.
  - Otherwise fwd_rs1 = wb_data under the same test against wb_*.
  - Otherwise fwd_rs1 = the registered rs1_data.
  - fwd_rs2 is computed the same way against rs2_addr. MEM has priority over WB. x0 is never forwarded.
  - No ID-stage write-through: same-cycle WB→ID bypass is the register file's responsibility.
- Operand select:
  - oprand_a = opa_sel ? ex_pc : fwd_rs1.
  - oprand_b = opb_sel ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2, independent of opb_sel.
- Load-use hazard:
  - load_use_hazard = ex_valid & ex_is_load & ex_rd_wren & ex_rd_addr != 0 & id_valid & ((id_rs1_used & id_rs1_addr == ex_rd_addr) | (id_rs2_used & id_rs2_addr == ex_rd_addr)).
  - The controller responds by stalling IF/ID and flushing this stage for one cycle. This block does not self-flush.
- Outputs do not depend combinationally on id_* inputs, except load_use_hazard.
- All widths are exact XLEN; no extension or arithmetic is performed here.

Test Plan:
- Reset: assert rst while stall = 1 and id_valid = 1 → next cycle ex_valid = 0, oprand_a = 0, oprand_b = 0, alu_sel = 0, load_use_hazard = 0.
- Basic load: id_rs1_data = 5, id_imm = 0xFFFFFFFC, opb_sel = 1, alu_sel = ADD → next cycle oprand_a = 5, oprand_b = 0xFFFFFFFC, ex_valid = 1.
- Forward priority: ex rs1_addr = 3; mem writes x3 = 0x11; wb writes x3 = 0x22 → oprand_a = 0x11. Drop mem_valid → 0x22. Set rs1_addr = 0 with both matching → registered rs1_data.
- Load-use: ex holds lw x7 (is_load = 1); id_valid = 1, id_rs2_used = 1, id_rs2_addr = 7 → load_use_hazard = 1. Same case with id_rs2_used = 0 or ex_rd_addr = 0 → 0.
- Stall with retiring producer: stall = 1 for 3 cycles while wb writes x4 = 0xABCD in cycle 1 only (ex rs2_addr = 4, opb_sel = 0) → oprand_b = 0xABCD in cycles 1–3 and after release; all other fields unchanged.
- Flush vs stall: flush = 1 and stall = 1 together with a live EX instruction → next cycle ex_valid = 0, ex_rd_wren = 0, oprand_a = 0.
